// File: rtl/tv_code_player_pkg.sv
// tv_code_player_pkg: shared states, ROM entry layout constants and helpers for the TV-code player
package tv_code_player_pkg;
  typedef enum logic [3:0] {
    IDLE, HDR_H, HDR_N, FETCH0, FETCH1, FETCH2, FETCH3, MARK, SPACE, GAP
  } state_t;
  localparam int HDR_H_OFS = 0;
  localparam int HDR_N_OFS = 1;
  localparam int HDR_BYTES = HDR_N_OFS + 1;
  localparam int PAIR_BYTES = 4;
  localparam logic [7:0] END_OF_TABLE = 8'h00;
  function automatic int entry_bytes(input int pairs);
    return HDR_BYTES + pairs * PAIR_BYTES;
  endfunction
endpackage

// File: rtl/tv_code_tick.sv
// tv_code_tick: duration timer; ports clk/rst_n, load+ticks restart it, count advances it, expire flags the last clock
module tv_code_tick #(
  parameter int TICK_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        count,
  input  logic [15:0] ticks,
  output logic        expire
);
  localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);
  logic [PW-1:0] pre;
  logic [15:0] rem;
  logic tick_end;
  assign tick_end = pre == LAST;
  assign expire = count && tick_end && rem == 16'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      rem <= '0;
    end else if (load) begin
      pre <= '0;
      rem <= ticks;
    end else if (count) begin
      pre <= tick_end ? '0 : pre + 1'b1;
      rem <= tick_end ? rem - 1'b1 : rem;
    end
  end
endmodule

// File: rtl/tv_code_player.sv
// tv_code_player: walks the TV-code ROM and plays each entry as carrier-modulated IR bursts; ports start/stop control, rom_* bus, ir_out/busy/done/error/code_index status
module tv_code_player
  import tv_code_player_pkg::*;
#(
  parameter int ADDRESS_BITS = 13,
  parameter int TICK_CYCLES = 10,
  parameter int GAP_TICKS = 25000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  output logic [ADDRESS_BITS-1:0] rom_address,
  input  logic [7:0]              rom_data,
  input  logic                    rom_overflow,
  output logic                    ir_out,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [7:0]              code_index
);
  state_t state, next, after_mark, after_space;
  logic [7:0] h, n, cc;
  logic [15:0] on, off, off_v, load_val;
  logic fetch_st, accept, ovf, done_n, load, count, expire;
  tv_code_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk(clk), .rst_n(rst_n), .load(load), .count(count), .ticks(load_val), .expire(expire)
  );
  assign count = state inside {MARK, SPACE, GAP};
  always_comb begin
    fetch_st = state inside {HDR_H, HDR_N, FETCH0, FETCH1, FETCH2, FETCH3};
    // off_lo is still on the bus during FETCH3, so the skip decision uses it directly
    off_v = state == FETCH3 ? {off[15:8], rom_data} : off;
    after_space = n != 8'd0 ? FETCH0 : (GAP_TICKS == 0 ? HDR_H : GAP);
    after_mark = off_v != 16'd0 ? SPACE : after_space;
    accept = 1'b0;
    ovf = 1'b0;
    done_n = 1'b0;
    next = state;
    if (stop) next = IDLE;
    else if (fetch_st && rom_overflow) begin
      ovf = 1'b1;
      done_n = 1'b1;
      next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          accept = start;
          next = start ? HDR_H : IDLE;
        end
        HDR_H: next = HDR_N;
        HDR_N: begin
          done_n = rom_data == END_OF_TABLE;
          next = done_n ? IDLE : FETCH0;
        end
        FETCH0: next = FETCH1;
        FETCH1: next = FETCH2;
        FETCH2: next = FETCH3;
        FETCH3: next = on != 16'd0 ? MARK : after_mark;
        MARK: next = expire ? after_mark : MARK;
        SPACE: next = expire ? after_space : SPACE;
        GAP: next = expire ? HDR_H : GAP;
        default: next = IDLE;
      endcase
    end
    load = next != state && next inside {MARK, SPACE, GAP};
    load_val = next == MARK ? on : next == SPACE ? off_v : 16'(GAP_TICKS);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rom_address <= '0;
      ir_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      code_index <= '0;
      h <= '0;
      n <= '0;
      cc <= '0;
      on <= '0;
      off <= '0;
    end else begin
      state <= next;
      busy <= next != IDLE;
      done <= done_n;
      error <= accept ? 1'b0 : error | ovf;
      rom_address <= accept ? ADDRESS_BITS'(HDR_H_OFS) :
                     (fetch_st && !stop && !rom_overflow) ? rom_address + 1'b1 : rom_address;
      code_index <= accept ? 8'd0 : (state == HDR_N && next == FETCH0) ? code_index + 8'd1 : code_index;
      h <= state == HDR_H ? rom_data : h;
      n <= state == HDR_N ? rom_data : state == FETCH0 ? n - 8'd1 : n;
      on[15:8] <= state == FETCH0 ? rom_data : on[15:8];
      on[7:0] <= state == FETCH1 ? rom_data : on[7:0];
      off[15:8] <= state == FETCH2 ? rom_data : off[15:8];
      off[7:0] <= state == FETCH3 ? rom_data : off[7:0];
      // cc counts clocks already shown in the current carrier phase; restarts on MARK entry
      cc <= state != MARK ? 8'd1 : cc == h ? 8'd1 : cc + 8'd1;
      ir_out <= next != MARK ? 1'b0 : state != MARK ? 1'b1 : h == 8'd0 ? 1'b1 :
                cc == h ? ~ir_out : ir_out;
    end
  end
endmodule

// File: tb/tb_tv_code_player.sv
// tb_tv_code_player: randomized and directed checks of tv_code_player against a per-cycle waveform model
module tb_tv_code_player;
  localparam int TC = 10;
  localparam int GT = 2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [12:0] rom_address;
  logic [7:0] rom_data, code_index;
  logic rom_overflow, ir_out, busy, done, error;
  logic [7:0] rom [0:8191];
  int rom_size = 8192;
  int wp;
  int n_checks = 0, n_fail = 0;
  bit exp_q[$];
  bit exp_err;
  int exp_code;
  assign rom_data = rom[rom_address];
  assign rom_overflow = int'(rom_address) >= rom_size;
  tv_code_player #(.ADDRESS_BITS(13), .TICK_CYCLES(TC), .GAP_TICKS(GT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .rom_address(rom_address),
    .rom_data(rom_data), .rom_overflow(rom_overflow), .ir_out(ir_out), .busy(busy),
    .done(done), .error(error), .code_index(code_index)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 8'h00;
    wp = 0;
    rom_size = 8192;
  endtask
  task automatic put(input int b);
    rom[wp] = 8'(b);
    wp++;
  endtask
  task automatic put_pair(input int on_t, input int off_t);
    put(on_t >> 8); put(on_t & 255); put(off_t >> 8); put(off_t & 255);
  endtask
  function automatic bit rd(inout int a, output int v);
    exp_q.push_back(1'b0);
    if (a >= rom_size) begin
      exp_err = 1'b1;
      v = 0;
      return 1'b1;
    end
    v = int'(rom[a]);
    a++;
    return 1'b0;
  endfunction
  function automatic void build();
    int a = 0;
    int hh, nn, b0, b1, b2, b3;
    bit ovf;
    exp_q.delete();
    exp_err = 1'b0;
    exp_code = 0;
    while (1) begin
      if (rd(a, hh)) break;
      if (rd(a, nn)) break;
      if (nn == 0) break;
      exp_code++;
      ovf = 1'b0;
      for (int p = 0; p < nn; p++) begin
        if (rd(a, b0) || rd(a, b1) || rd(a, b2) || rd(a, b3)) begin
          ovf = 1'b1;
          break;
        end
        for (int k = 0; k < (b0 * 256 + b1) * TC; k++)
          exp_q.push_back(hh == 0 ? 1'b1 : ((k / hh) % 2 == 0));
        for (int k = 0; k < (b2 * 256 + b3) * TC; k++) exp_q.push_back(1'b0);
      end
      if (ovf) break;
      for (int k = 0; k < GT * TC; k++) exp_q.push_back(1'b0);
    end
  endfunction
  task automatic run(input string tag, input int pulse_at, input bit hold);
    build();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        check({tag, " addr0"}, 32'(rom_address), 0);
        check({tag, " err_clr"}, 32'(error), 0);
        check({tag, " idx0"}, 32'(code_index), 0);
      end
      check($sformatf("%s ir@%0d", tag, i), 32'(ir_out), 32'(exp_q[i]));
      check($sformatf("%s busy@%0d", tag, i), 32'(busy), 1);
      check($sformatf("%s done@%0d", tag, i), 32'(done), 0);
      if (!hold) start = (i == pulse_at);
    end
    @(negedge clk);
    check({tag, " done"}, 32'(done), 1);
    check({tag, " busy_end"}, 32'(busy), 0);
    check({tag, " ir_end"}, 32'(ir_out), 0);
    check({tag, " error"}, 32'(error), 32'(exp_err));
    check({tag, " code_index"}, 32'(code_index), 32'(exp_code & 255));
    if (hold) begin
      @(negedge clk);
      check({tag, " restart"}, 32'(busy), 1);
      check({tag, " restart_addr"}, 32'(rom_address), 0);
      start = 1'b0;
      stop = 1'b1;
      @(negedge clk);
      check({tag, " stop_busy"}, 32'(busy), 0);
      stop = 1'b0;
    end else begin
      @(negedge clk);
      check({tag, " done_once"}, 32'(done), 0);
    end
  endtask
  task automatic basic_entry(input int hh);
    clear_rom();
    put(hh); put(1); put_pair(2, 1);
    put(0); put(0);
  endtask
  initial begin
    #22;
    check("rst ir", 32'(ir_out), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst error", 32'(error), 0);
    check("rst idx", 32'(code_index), 0);
    check("rst addr", 32'(rom_address), 0);
    @(negedge clk);
    rst_n = 1'b1;
    basic_entry(3);
    run("h3", -1, 1'b0);
    basic_entry(0);
    run("h0", -1, 1'b0);
    clear_rom();
    put(2); put(1); put_pair(1, 0);
    put(1); put(1); put_pair(1, 1);
    put(0); put(0);
    run("two", -1, 1'b0);
    clear_rom();
    put(5); put(1); put_pair(16'h0101, 16'h0100);
    put(7); put(0);
    run("bigend", -1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      int ne, nn;
      clear_rom();
      ne = int'($urandom_range(1, 3));
      for (int e = 0; e < ne; e++) begin
        put(int'($urandom_range(0, 4)));
        nn = int'($urandom_range(1, 3));
        put(nn);
        for (int p = 0; p < nn; p++) put_pair(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      put(int'($urandom_range(0, 255))); put(0);
      run($sformatf("rnd%0d", r), r * 7, 1'b0);
    end
    basic_entry(3);
    build();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("stop ir@%0d", i), 32'(ir_out), 32'(exp_q[i]));
      if (i == 10) stop = 1'b1;
    end
    @(negedge clk);
    stop = 1'b0;
    check("stop ir", 32'(ir_out), 0);
    check("stop busy", 32'(busy), 0);
    check("stop error", 32'(error), 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check($sformatf("stop nodone@%0d", i), 32'(done), 0);
    end
    clear_rom();
    for (int e = 0; e < 7; e++) begin
      put(1); put(200);
      for (int p = 0; p < 200; p++) put_pair(int'($urandom_range(0, 1)), 0);
    end
    rom_size = 4740;
    run("ovf", -1, 1'b0);
    basic_entry(2);
    run("busy_start", 12, 1'b1);
    basic_entry(3);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst ir", 32'(ir_out), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst2 ir", 32'(ir_out), 0);
    check("rst2 busy", 32'(busy), 0);
    check("rst2 done", 32'(done), 0);
    check("rst2 error", 32'(error), 0);
    check("rst2 idx", 32'(code_index), 0);
    check("rst2 addr", 32'(rom_address), 0);
    @(negedge clk);
    rst_n = 1'b1;
    basic_entry(1);
    run("after_rst", -1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tv_code_player.md
# tv_code_player

Sequencer that walks the TV-code ROM image from address 0, parses each code entry and drives the IR LED output with carrier-modulated mark/space bursts. Between entries it inserts a fixed inter-code gap. It stops at the end-of-table marker or on a ROM address overflow. It sits between the top-level button/control logic and the TV-code ROM: it is the sole master of the ROM's address bus.

## Interface
Parameters:
- ADDRESS_BITS, 13: ROM address width.
- TICK_CYCLES, 10: clk cycles per duration tick (≥ 1).
- GAP_TICKS, 25000: inter-code gap length in ticks (16-bit).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled; begins a run from address 0 when idle.
- stop  in  1  aborts a run.
- rom_address  out  ADDRESS_BITS  ROM read address.
- rom_data  in  8  ROM byte; combinational, valid in the same cycle as rom_address.
- rom_overflow  in  1  ROM flag: rom_address ≥ ROM size.
- ir_out  out  1  IR LED drive, active high.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run completion.
- error  out  1  sticky overflow flag; cleared by the next accepted start.
- code_index  out  8  number of entries started in the current run.

## Operation
- ROM entry format:
  - byte0 = carrier half-period H.
  - byte1 = pair count N. N = 0 is the end-of-table marker; H is ignored in that case.
  - Then N pairs of 4 bytes each: on_hi, on_lo, off_hi, off_lo. Durations are 16-bit big-endian, in ticks.
- FSM states: IDLE, HDR_H, HDR_N, FETCH0..FETCH3, MARK, SPACE, GAP.
- IDLE: start=1 → rom_address=0, error=0, code_index=0, go to HDR_H.
- Each FETCH/HDR state reads one byte per cycle and increments rom_address once per byte.
- HDR_N:
  - N=0 → done pulse, go to IDLE.
  - Otherwise → code_index+1, go to FETCH0.
- After FETCH3 → MARK.
  - MARK lasts on×TICK_CYCLES clocks.
  - Carrier: H=0 → ir_out solid 1. H≥1 → ir_out starts 1 and toggles every H clocks. Carrier phase restarts at every MARK entry.
  - on=0 skips MARK.
- SPACE: ir_out=0 for off×TICK_CYCLES clocks; off=0 skips SPACE.
  - Pairs remaining → FETCH0.
  - Last pair done → GAP.
- GAP: ir_out=0 for GAP_TICKS×TICK_CYCLES clocks, then → HDR_H (next entry).
- rom_overflow=1 in any HDR/FETCH cycle → error=1, done pulse, IDLE. The byte read in that cycle is discarded.
- stop=1 in any non-IDLE state → IDLE next cycle; ir_out=0, no done pulse, error unchanged.
  - stop has priority over every other transition.
  - stop with start both high in IDLE: stay in IDLE.
- start while busy is ignored. A start held high after done begins a new run on the next cycle.
- code_index wraps at 255→0.

## Timing
- Reset values: rom_address=0, ir_out=0, busy=0, done=0, error=0, code_index=0, FSM=IDLE.
- ir_out, busy, done and error are registered outputs.
- busy=1 from the cycle after start is accepted until the cycle done pulses or stop is taken.
- Start accepted to first ir_out=1: 2 header cycles + 4 fetch cycles = 6 clocks after the start cycle.
- Exact durations:
  - mark = on×TICK_CYCLES clocks.
  - space = off×TICK_CYCLES clocks, plus 4 fetch clocks (ir_out=0) before each following mark.
- Header costs 2 clocks (ir_out=0) after each GAP.
- The tick prescaler restarts at each MARK, SPACE and GAP entry, so there is no partial first tick.
- done is high for exactly one cycle; busy falls in that same cycle.

## Structure
- Package tv_code_player_pkg holds:
  - the state enum;
  - header byte offsets and PAIR_BYTES=4;
  - the end-of-table value 8'h00.
- Sub-module tv_code_tick:
  - tick prescaler plus 16-bit down-counter;
  - inputs: load, count;
  - output: expire pulse;
  - shared by MARK, SPACE and GAP.
- Carrier divider (8-bit) stays inline.

## Test plan
- Entry H=3, N=1, on=2, off=1, then 0x00; TICK_CYCLES=10, GAP_TICKS=2 → ir_out 1,1,1,0,0,0,… for 20 clocks, then 0; after 10+20+2 clocks done pulses once; code_index=1; error=0.
- Same entry with H=0 → ir_out solid 1 for exactly 20 clocks.
- Two entries with pairs (1,0) then (1,1) → no SPACE cycles on the zero-off pair; code_index reaches 2 before done.
- stop asserted in the 5th MARK clock → ir_out=0 and busy=0 next cycle, done never pulses.
- N=200 in an entry overrunning ROM size (rom_overflow driven at 4740) → error=1, done pulse, ir_out=0; next start clears error.
- start pulsed while busy → no restart, rom_address sequence unaffected. Reset asserted mid-MARK → all outputs at reset values immediately.
